// File: rtl/pipeline_control_unit.sv
// pipeline_control_unit
//   Sequences the 5-stage pipeline. Produces PC / IF/ID / later-stage enables,
//   the IF/ID flush and the ID/EX bubble, and covers debug run/step, load-use
//   stalls, taken-branch flushes and the halt drain.
//   Every state update happens on the falling edge, matching the stage registers.
// Ports
//   clock, reset_i                  falling-edge clock, synchronous active-high reset
//   run_i, step_i                   debug run level / single-step pulse (sampled in IDLE)
//   id_ex_mem_read_i, id_ex_register_rw_i, if_id_rs_i, if_id_rt_i, if_id_uses_rt_i
//                                   load-use hazard inputs
//   branch_taken_i                  taken branch/jump resolved this cycle
//   halt_decoded_i, halt_wb_i       halt seen in decode / reached writeback
//   en_pc_o, en_if_id_o, en_pipeline_o, flush_if_id_o, bubble_id_ex_o
//                                   combinational stage controls
//   halted_o, drain_error_o         sticky status
//   state_o, cycle_count_o          debug readout
module pipeline_control_unit #(
  parameter int NB_REG        = 5,
  parameter int NB_CNT        = 32,
  parameter int DRAIN_TIMEOUT = 8
) (
  input  logic              clock,
  input  logic              reset_i,
  input  logic              run_i,
  input  logic              step_i,
  input  logic              id_ex_mem_read_i,
  input  logic [NB_REG-1:0] id_ex_register_rw_i,
  input  logic [NB_REG-1:0] if_id_rs_i,
  input  logic [NB_REG-1:0] if_id_rt_i,
  input  logic              if_id_uses_rt_i,
  input  logic              branch_taken_i,
  input  logic              halt_decoded_i,
  input  logic              halt_wb_i,
  output logic              en_pc_o,
  output logic              en_if_id_o,
  output logic              en_pipeline_o,
  output logic              flush_if_id_o,
  output logic              bubble_id_ex_o,
  output logic              halted_o,
  output logic              drain_error_o,
  output logic [2:0]        state_o,
  output logic [NB_CNT-1:0] cycle_count_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_STEP   = 3'd2,
    S_DRAIN  = 3'd3,
    S_HALTED = 3'd4
  } state_t;

  localparam int NB_DRN = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [NB_DRN-1:0] DRAIN_LAST = NB_DRN'(DRAIN_TIMEOUT - 1);

  state_t            state, state_nxt;
  logic [NB_DRN-1:0] drain_cnt;
  logic [NB_CNT-1:0] cycle_cnt;
  logic              halted_q, drain_err_q;
  logic              executing, load_use, drain_timeout;

  assign executing = (state == S_RUN) || (state == S_STEP);

  // rw==0 is the hardwired zero register and never creates a dependency.
  assign load_use = id_ex_mem_read_i && (id_ex_register_rw_i != '0) &&
                    ((id_ex_register_rw_i == if_id_rs_i) ||
                     (if_id_uses_rt_i && (id_ex_register_rw_i == if_id_rt_i)));

  // A writeback halt arriving on the last allowed cycle still counts as clean.
  assign drain_timeout = (state == S_DRAIN) && !halt_wb_i && (drain_cnt == DRAIN_LAST);

  // State register
  always_ff @(negedge clock) begin
    if (reset_i) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (run_i)       state_nxt = S_RUN;
                else if (step_i) state_nxt = S_STEP;
      S_RUN:    if (halt_decoded_i) state_nxt = S_DRAIN;
      // A step always lasts one cycle; a halt decoded in it drains on its own.
      S_STEP:   state_nxt = halt_decoded_i ? S_DRAIN : S_IDLE;
      S_DRAIN:  if (halt_wb_i || drain_timeout) state_nxt = S_HALTED;
      S_HALTED: state_nxt = S_HALTED;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    en_pc_o        = 1'b0;
    en_if_id_o     = 1'b0;
    en_pipeline_o  = 1'b0;
    flush_if_id_o  = 1'b0;
    bubble_id_ex_o = 1'b0;
    if (executing) begin
      en_pipeline_o = 1'b1;
      if (branch_taken_i) begin
        // The stalled instruction is on the wrong path, so the flush wins.
        en_pc_o       = 1'b1;
        en_if_id_o    = 1'b1;
        flush_if_id_o = 1'b1;
      end else if (load_use) begin
        bubble_id_ex_o = 1'b1;
      end else begin
        en_pc_o    = 1'b1;
        en_if_id_o = 1'b1;
      end
    end else if (state == S_DRAIN) begin
      // Stop fetching and let the in-flight instructions reach writeback.
      en_pipeline_o = 1'b1;
      flush_if_id_o = 1'b1;
    end
  end

  // Counters and sticky flags
  always_ff @(negedge clock) begin
    if (reset_i) begin
      drain_cnt   <= '0;
      cycle_cnt   <= '0;
      halted_q    <= 1'b0;
      drain_err_q <= 1'b0;
    end else begin
      drain_cnt <= (state == S_DRAIN) ? drain_cnt + 1'b1 : '0;
      if (en_pipeline_o && (cycle_cnt != '1)) cycle_cnt <= cycle_cnt + 1'b1;
      if (state_nxt == S_HALTED) halted_q <= 1'b1;
      if (drain_timeout)         drain_err_q <= 1'b1;
    end
  end

  assign halted_o      = halted_q;
  assign drain_error_o = drain_err_q;
  assign state_o       = state;
  assign cycle_count_o = cycle_cnt;

endmodule
